// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, the IF/ID pipeline register and
// the redirect/flush handshake toward the later pipeline buffers.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [3:0]  opcode_id,
  output logic [5:0]  rd_id,
  output logic [5:0]  rs_id,
  output logic [5:0]  rt_id,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic        flush,
  output logic [31:0] pc,
  output logic [15:0] fetch_count,
  output logic [15:0] squash_count
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    REDIRECT
  } state_t;

  state_t state, state_nxt;
  logic   take_redirect;
  logic   capture;

  assign imem_addr = pc[7:0];

  // REDIRECT fetches like FETCH; it differs only in that IF/ID is empty while in it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt     = state;
    take_redirect = 1'b0;
    capture       = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH, REDIRECT: begin
        if (redirect) begin
          take_redirect = 1'b1;
          state_nxt     = REDIRECT;
        end else if (!stall) begin
          capture   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      valid_id     <= 1'b0;
      flush        <= 1'b0;
      opcode_id    <= '0;
      rd_id        <= '0;
      rs_id        <= '0;
      rt_id        <= '0;
      pc_id        <= '0;
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      state <= state_nxt;
      flush <= take_redirect;
      if (take_redirect) begin
        // Wrong-path word is dropped; IF/ID fields read as zero while empty.
        pc           <= redirect_addr;
        valid_id     <= 1'b0;
        opcode_id    <= '0;
        rd_id        <= '0;
        rs_id        <= '0;
        rt_id        <= '0;
        pc_id        <= '0;
        squash_count <= squash_count + 16'd1;
      end else if (capture) begin
        pc          <= pc + 32'd1;
        valid_id    <= 1'b1;
        opcode_id   <= imem_data[31:28];
        rd_id       <= imem_data[27:22];
        rs_id       <= imem_data[21:16];
        rt_id       <= imem_data[15:10];
        pc_id       <= pc;
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// stall/redirect/reset traffic compared against a behavioural fetch model.
module tb_if_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;

  logic [7:0]  imem_addr, imem_addr2;
  logic [31:0] imem_data, imem_data2;
  logic [3:0]  opcode_id, opcode_id2;
  logic [5:0]  rd_id, rs_id, rt_id, rd_id2, rs_id2, rt_id2;
  logic [31:0] pc_id, pc, pc_id2, pc2;
  logic        valid_id, flush, valid_id2, flush2;
  logic [15:0] fetch_count, squash_count, fetch_count2, squash_count2;

  logic [31:0] mem [256];

  assign imem_data  = mem[imem_addr];
  assign imem_data2 = mem[imem_addr2];

  always #5 clock = ~clock;

  if_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .imem_addr(imem_addr), .imem_data(imem_data),
    .opcode_id(opcode_id), .rd_id(rd_id), .rs_id(rs_id), .rt_id(rt_id),
    .pc_id(pc_id), .valid_id(valid_id), .flush(flush), .pc(pc),
    .fetch_count(fetch_count), .squash_count(squash_count)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .opcode_id(opcode_id2), .rd_id(rd_id2), .rs_id(rs_id2), .rt_id(rt_id2),
    .pc_id(pc_id2), .valid_id(valid_id2), .flush(flush2), .pc(pc2),
    .fetch_count(fetch_count2), .squash_count(squash_count2)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: a PC, a one-cycle boot delay and the IF/ID contents.
  logic [31:0] m_pc, m_pcid;
  logic        m_boot, m_valid, m_flush;
  logic [3:0]  m_op;
  logic [5:0]  m_rd, m_rs, m_rt;
  logic [15:0] m_fc, m_sq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_ifid();
    m_valid = 1'b0;
    m_op = '0; m_rd = '0; m_rs = '0; m_rt = '0; m_pcid = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    logic [31:0] word;
    if (reset) begin
      m_pc = 32'h0; m_boot = 1'b1; m_flush = 1'b0; m_fc = '0; m_sq = '0;
      clear_ifid();
    end else begin
      m_flush = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (redirect) begin
        m_pc = redirect_addr; m_flush = 1'b1; m_sq = m_sq + 16'd1;
        clear_ifid();
      end else if (!stall) begin
        word   = mem[m_pc[7:0]];
        m_op   = word[31:28]; m_rd = word[27:22]; m_rs = word[21:16]; m_rt = word[15:10];
        m_pcid = m_pc; m_valid = 1'b1; m_fc = m_fc + 16'd1;
        m_pc   = m_pc + 32'd1;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".imem_addr"}, {24'h0, imem_addr}, {24'h0, m_pc[7:0]});
    check({tag, ".valid_id"}, {31'h0, valid_id}, {31'h0, m_valid});
    check({tag, ".flush"}, {31'h0, flush}, {31'h0, m_flush});
    check({tag, ".opcode_id"}, {28'h0, opcode_id}, {28'h0, m_op});
    check({tag, ".rd_id"}, {26'h0, rd_id}, {26'h0, m_rd});
    check({tag, ".rs_id"}, {26'h0, rs_id}, {26'h0, m_rs});
    check({tag, ".rt_id"}, {26'h0, rt_id}, {26'h0, m_rt});
    check({tag, ".pc_id"}, pc_id, m_pcid);
    check({tag, ".fetch_count"}, {16'h0, fetch_count}, {16'h0, m_fc});
    check({tag, ".squash_count"}, {16'h0, squash_count}, {16'h0, m_sq});
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'(k) << 28;

    // Reset state
    tick(); tick();
    check_all("reset");
    check("reset.pc", pc, 32'h0);
    check("reset.wrap_pc", pc2, 32'hFFFF_FFFF);
    check("reset.wrap_addr", {24'h0, imem_addr2}, 32'hFF);

    // Boot cycle, then sequential fetch
    reset = 1'b0;
    tick();
    check_all("boot");
    check("boot.valid", {31'h0, valid_id}, 32'h0);
    check("boot.wrap_addr", {24'h0, imem_addr2}, 32'hFF);
    for (int n = 0; n < 3; n++) begin
      tick();
      check_all("seq");
      check("seq.opcode", {28'h0, opcode_id}, 32'(n));
      check("seq.pc", pc, 32'(n + 1));
      if (n == 0) begin
        check("wrap.pc", pc2, 32'h0);
        check("wrap.addr", {24'h0, imem_addr2}, 32'h0);
      end
    end
    check("seq.fetch_count", {16'h0, fetch_count}, 32'd3);

    // Stall at pc=5 for three cycles
    tick(); tick();
    check("stall.pre_pc", pc, 32'd5);
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check_all("stall");
      check("stall.pc", pc, 32'd5);
      check("stall.opcode", {28'h0, opcode_id}, 32'd4);
      check("stall.fetch_count", {16'h0, fetch_count}, 32'd5);
    end
    stall = 1'b0;
    tick();
    check("stall.resume_pcid", pc_id, 32'd5);
    check("stall.resume_pc", pc, 32'd6);

    // Redirect while stalled at pc=7
    tick();
    check("redir.pre_pc", pc, 32'd7);
    stall = 1'b1; redirect = 1'b1; redirect_addr = 32'h40;
    tick();
    check_all("redir");
    check("redir.pc", pc, 32'h40);
    check("redir.flush", {31'h0, flush}, 32'h1);
    check("redir.valid", {31'h0, valid_id}, 32'h0);
    check("redir.squash", {16'h0, squash_count}, 32'h1);
    stall = 1'b0; redirect = 1'b0;
    tick();
    check_all("redir_after");
    check("redir.flush_drop", {31'h0, flush}, 32'h0);
    check("redir.pc_id", pc_id, 32'h40);

    // Back-to-back redirects
    redirect = 1'b1; redirect_addr = 32'h10;
    tick();
    check_all("b2b1");
    check("b2b.flush1", {31'h0, flush}, 32'h1);
    redirect_addr = 32'h20;
    tick();
    check_all("b2b2");
    check("b2b.flush2", {31'h0, flush}, 32'h1);
    check("b2b.valid", {31'h0, valid_id}, 32'h0);
    check("b2b.pc", pc, 32'h20);
    redirect = 1'b0;
    tick();
    check_all("b2b3");
    check("b2b.pc_id", pc_id, 32'h20);
    check("b2b.flush_end", {31'h0, flush}, 32'h0);

    // Reset coinciding with redirect
    reset = 1'b1; redirect = 1'b1; redirect_addr = 32'h99;
    tick();
    check_all("rst_redir");
    check("rst_redir.flush", {31'h0, flush}, 32'h0);
    check("rst_redir.pc", pc, 32'h0);
    check("rst_redir.squash", {16'h0, squash_count}, 32'h0);
    reset = 1'b0; redirect = 1'b0;
    tick();
    check("rst_redir.flush_next", {31'h0, flush}, 32'h0);

    // Random traffic against the model
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(99) < 3);
      stall         = ($urandom_range(99) < 30);
      redirect      = ($urandom_range(99) < 15);
      redirect_addr = $urandom;
      tick();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
